// File: rtl/cdb_complete_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_complete_arbiter_pkg
//   Shared definitions for the complete-bus (CDB) arbiter:
//   - CDB_WIDTH : number of completion slots broadcast per cycle
//   - ROB_W     : ROB index width
//   - XLEN      : architectural PC width
//   - CDB_TAG_W : physical register tag width carried on the bus
//   - cdb_packet_t : one registered CDB slot
//   - wrap_inc  : modulo-n increment used for the round-robin pointer
// ---------------------------------------------------------------------------
package cdb_complete_arbiter_pkg;

   localparam int CDB_WIDTH = 3;
   localparam int ROB_W     = 5;
   localparam int XLEN      = 32;
   localparam int CDB_TAG_W = 5;

   typedef struct packed {
      logic                 valid;
      logic [ROB_W-1:0]     rob_idx;
      logic [CDB_TAG_W-1:0] tag;
      logic                 precise_state;
      logic [XLEN-1:0]      target_pc;
   } cdb_packet_t;

   // Next index after idx in a ring of n entries.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_rr_pick3.sv
// ---------------------------------------------------------------------------
// cdb_rr_pick3
//   Combinational round-robin picker. Scans the request vector starting at
//   rr_ptr (rotated view), takes the first CDB_WIDTH set bits and maps them
//   back to requester indices. The k-th pick lands in slot k.
// Ports
//   req      in  NUM_REQ              request bits
//   rr_ptr   in  IDX_W                first index to consider
//   grant_oh out CDB_WIDTH x NUM_REQ  one-hot grant per slot (0 if slot unused)
//   slot_vld out CDB_WIDTH            slot k holds a grant
//   slot_idx out CDB_WIDTH x IDX_W    requester index per slot (0 if unused)
//   last_idx out IDX_W                index of the last (highest slot) grant
// ---------------------------------------------------------------------------
module cdb_rr_pick3
   import cdb_complete_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 6,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [IDX_W-1:0]                    rr_ptr,
   output logic [CDB_WIDTH-1:0][NUM_REQ-1:0]   grant_oh,
   output logic [CDB_WIDTH-1:0]                slot_vld,
   output logic [CDB_WIDTH-1:0][IDX_W-1:0]     slot_idx,
   output logic [IDX_W-1:0]                    last_idx
);

   always_comb begin
      int n_found;
      int pos;
      grant_oh = '0;
      slot_vld = '0;
      slot_idx = '0;
      last_idx = '0;
      n_found  = 0;
      pos      = 0;
      // j walks the rotated vector; pos is the unrotated requester index.
      for (int j = 0; j < NUM_REQ; j++) begin
         pos = j + int'(rr_ptr);
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (req[pos] && (n_found < CDB_WIDTH)) begin
            slot_vld[n_found]      = 1'b1;
            slot_idx[n_found]      = IDX_W'(pos);
            grant_oh[n_found][pos] = 1'b1;
            last_idx               = IDX_W'(pos);
            n_found                = n_found + 1;
         end
      end
   end

endmodule

// File: rtl/cdb_complete_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_complete_arbiter
//   Schedules functional-unit completions onto the 3-wide complete bus.
//   Up to 3 requesters are granted per cycle in round-robin order; granted
//   results are registered and broadcast one cycle later. Branch recovery
//   blocks grants and empties the next-cycle bus.
// Handshake: an FU holds req_* stable while req_valid && !req_ready; a
//   transfer happens in a cycle where req_valid && req_ready are both high.
//   Withdrawing req_valid before it is granted is legal.
// Ports
//   clock, reset          clock; asynchronous active-low reset
//   req_valid/rob_idx/tag/mispredict/target_pc   per-FU completion request
//   req_ready             per-FU grant (combinational)
//   BPRecoverEN           branch recovery squash
//   complete_valid/entry/tag, precise_state_valid, target_pc   CDB slots
//   contention_cnt        saturating count of cycles with denied requests
// TAG_W must match the package CDB_TAG_W (bus packet field width).
// ---------------------------------------------------------------------------
module cdb_complete_arbiter
   import cdb_complete_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 6,
   parameter int TAG_W   = CDB_TAG_W,
   parameter int CNT_W   = 16
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0][ROB_W-1:0]       req_rob_idx,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]       req_tag,
   input  logic [NUM_REQ-1:0]                  req_mispredict,
   input  logic [NUM_REQ-1:0][XLEN-1:0]        req_target_pc,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic                                BPRecoverEN,
   output logic [CDB_WIDTH-1:0]                complete_valid,
   output logic [CDB_WIDTH-1:0][ROB_W-1:0]     complete_entry,
   output logic [CDB_WIDTH-1:0][TAG_W-1:0]     complete_tag,
   output logic [CDB_WIDTH-1:0]                precise_state_valid,
   output logic [CDB_WIDTH-1:0][XLEN-1:0]      target_pc,
   output logic [CNT_W-1:0]                    contention_cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
   cdb_packet_t [CDB_WIDTH-1:0]       cdb_q, cdb_d;
   logic [CNT_W-1:0]                  contention_cnt_q, contention_cnt_d;

   logic [CDB_WIDTH-1:0][NUM_REQ-1:0] grant_oh;
   logic [CDB_WIDTH-1:0]              slot_vld;
   logic [CDB_WIDTH-1:0][IDX_W-1:0]   slot_idx;
   logic [IDX_W-1:0]                  last_idx;

   cdb_rr_pick3 #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req      (req_valid),
      .rr_ptr   (rr_ptr_q),
      .grant_oh (grant_oh),
      .slot_vld (slot_vld),
      .slot_idx (slot_idx),
      .last_idx (last_idx)
   );

   always_comb begin
      logic [NUM_REQ-1:0] grant_any;
      logic               do_grant;
      grant_any        = '0;
      cdb_d            = '0;
      rr_ptr_d         = rr_ptr_q;
      contention_cnt_d = contention_cnt_q;

      for (int k = 0; k < CDB_WIDTH; k++) begin
         grant_any = grant_any | grant_oh[k];
      end

      // Grants are visible only out of reset and outside recovery.
      do_grant  = reset && !BPRecoverEN;
      req_ready = do_grant ? grant_any : '0;

      if (do_grant) begin
         for (int k = 0; k < CDB_WIDTH; k++) begin
            if (slot_vld[k]) begin
               cdb_d[k].valid         = 1'b1;
               cdb_d[k].rob_idx       = req_rob_idx[slot_idx[k]];
               cdb_d[k].tag           = req_tag[slot_idx[k]];
               cdb_d[k].precise_state = req_mispredict[slot_idx[k]];
               // Recovery PC only travels with a mispredict.
               cdb_d[k].target_pc     = req_mispredict[slot_idx[k]] ?
                                        req_target_pc[slot_idx[k]] : '0;
            end
         end
         if (slot_vld[0]) begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(last_idx), NUM_REQ));
         end
         // More requesters than slots means somebody was denied.
         if (($countones(req_valid) > CDB_WIDTH) && (contention_cnt_q != '1)) begin
            contention_cnt_d = contention_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q         <= '0;
         cdb_q            <= '0;
         contention_cnt_q <= '0;
      end else begin
         rr_ptr_q         <= rr_ptr_d;
         cdb_q            <= cdb_d;
         contention_cnt_q <= contention_cnt_d;
      end
   end

   always_comb begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
         complete_valid[k]      = cdb_q[k].valid;
         complete_entry[k]      = cdb_q[k].rob_idx;
         complete_tag[k]        = cdb_q[k].tag;
         precise_state_valid[k] = cdb_q[k].precise_state;
         target_pc[k]           = cdb_q[k].target_pc;
      end
   end

   assign contention_cnt = contention_cnt_q;

endmodule
